// File: rtl/cache_bus_arbiter_pkg.sv
// Shared encodings for the I/D cache bus arbiter: FSM states, grant IDs and
// SRAM-like transfer size codes.
package cache_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Merges the I-cache and D-cache SRAM-like ports onto one downstream port,
// one outstanding transaction at a time, data-first with inst starvation guard.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests, mem_req low
// ADDR    | granted master's request forwarded, waiting for mem_addr_ok
// DATA    | address accepted, waiting for mem_data_ok
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state, state_nxt;
    gnt_t          gnt, gnt_nxt;
    logic [CW-1:0] starve_cnt, starve_cnt_nxt;
    logic          sel_inst;

    // Only meaningful when at least one request is pending.
    function automatic gnt_t arbitrate(input logic ireq, input logic dreq,
                                       input logic [CW-1:0] cnt);
        if (ireq && (!dreq || cnt == LIMIT))
            return GNT_INST;
        return GNT_DATA;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            gnt        <= GNT_INST;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        starve_cnt_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    gnt_nxt   = arbitrate(inst_req, data_req, starve_cnt);
                    state_nxt = ST_ADDR;
                    if (gnt_nxt == GNT_INST)
                        starve_cnt_nxt = '0;
                    else if (inst_req && starve_cnt != LIMIT)
                        starve_cnt_nxt = starve_cnt + 1'b1;
                end
            end
            ST_ADDR: if (mem_addr_ok) state_nxt = ST_DATA;
            ST_DATA: if (mem_data_ok) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are muxed by grant at all times; only mem_req is gated by state.
    assign sel_inst  = (gnt == GNT_INST);
    assign mem_req   = (state == ST_ADDR) && (sel_inst ? inst_req : data_req);
    assign mem_wr    = sel_inst ? inst_wr    : data_wr;
    assign mem_size  = sel_inst ? inst_size  : data_size;
    assign mem_addr  = sel_inst ? inst_addr  : data_addr;
    assign mem_wdata = sel_inst ? inst_wdata : data_wdata;

    assign inst_addr_ok = (state == ST_ADDR) &&  sel_inst && mem_addr_ok;
    assign data_addr_ok = (state == ST_ADDR) && !sel_inst && mem_addr_ok;
    assign inst_data_ok = (state == ST_DATA) &&  sel_inst && mem_data_ok;
    assign data_data_ok = (state == ST_DATA) && !sel_inst && mem_data_ok;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: table of single transactions plus
// hand-written arbitration, starvation, reset and stray-response sequences.
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    logic        clk, rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_inst;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        bit          is_inst;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat_a;
        int          lat_d;
    } vec_t;

    exp_t exp_q[$];

    cache_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        exp_t e;
        if (v.is_inst) begin
            inst_wr = v.wr; inst_size = v.size; inst_addr = v.addr; inst_wdata = v.wdata;
            inst_req = 1'b1;
        end else begin
            data_wr = v.wr; data_size = v.size; data_addr = v.addr; data_wdata = v.wdata;
            data_req = 1'b1;
        end
        e.is_inst = v.is_inst; e.wr = v.wr; e.size = v.size; e.addr = v.addr; e.wdata = v.wdata;
        exp_q.push_back(e);
    endtask

    // Downstream slave: waits for mem_req, acks after lat_a cycles, returns data
    // lat_d cycles after entering DATA; checks the popped expectation on the way.
    task automatic serve(input int lat_a, input int lat_d, input logic [31:0] rd,
                         input bit keep_data, input int exp_lat);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!mem_req && n < 20);
        chk("mem_req_seen", mem_req, 1);
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: got grant, required none pending");
            return;
        end
        e = exp_q.pop_front();
        if (!mem_req) return;
        if (exp_lat >= 0) chk("req_latency", 32'(n), 32'(exp_lat));
        for (int i = 0; i < lat_a; i++) begin
            mem_data_ok = 1'b1; #1;
            chk("addr_ok_wait", {30'd0, inst_addr_ok, data_addr_ok}, 0);
            chk("stray_data_ok_addr", {30'd0, inst_data_ok, data_data_ok}, 0);
            @(negedge clk); mem_data_ok = 1'b0; #1;
            chk("mem_req_hold", mem_req, 1);
        end
        mem_addr_ok = 1'b1; #1;
        chk("mem_addr",  mem_addr,  e.addr);
        chk("mem_wr",    mem_wr,    e.wr);
        chk("mem_size",  mem_size,  e.size);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("inst_addr_ok", inst_addr_ok, e.is_inst);
        chk("data_addr_ok", data_addr_ok, !e.is_inst);
        @(negedge clk);
        mem_addr_ok = 1'b0;
        if (e.is_inst) inst_req = 1'b0;
        else if (!keep_data) data_req = 1'b0;
        #1;
        chk("mem_req_in_data", mem_req, 0);
        for (int i = 0; i < lat_d; i++) @(negedge clk);
        mem_data_ok = 1'b1; mem_rdata = rd; #1;
        chk("inst_data_ok", inst_data_ok, e.is_inst);
        chk("data_data_ok", data_data_ok, !e.is_inst);
        chk("rdata", e.is_inst ? inst_rdata : data_rdata, rd);
        @(negedge clk); mem_data_ok = 1'b0; #1;
        chk("idle_bubble", mem_req, 0);
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0] = '{1'b1, 1'b0, SIZE_WORD, 32'h1FC0_0010, 32'h0000_0000, 32'h1111_2222, 0, 0};
        vecs[1] = '{1'b0, 1'b1, SIZE_WORD, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 0, 2};
        vecs[2] = '{1'b0, 1'b0, SIZE_BYTE, 32'h8000_2003, 32'h0000_0000, 32'h0000_00A5, 2, 0};
        vecs[3] = '{1'b1, 1'b0, SIZE_HALF, 32'h0040_0002, 32'h0000_0000, 32'h0000_3C3C, 1, 1};
        vecs[4] = '{1'b0, 1'b1, SIZE_HALF, 32'h8000_3002, 32'h0000_CAFE, 32'h0000_0000, 0, 0};

        rst = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;

        // Outputs held quiet during reset even with everything asserted.
        @(negedge clk); @(negedge clk);
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h5A5A_1234;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ok_flags", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        chk("rst_inst_rdata", inst_rdata, 32'h5A5A_1234);
        chk("rst_data_rdata", data_rdata, 32'h5A5A_1234);
        @(negedge clk);
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;

        // Boot fetch; request raised in the same cycle reset releases.
        @(negedge clk);
        rst = 1'b1;
        v = '{1'b1, 1'b0, SIZE_WORD, 32'hBFC0_0000, 32'h0, 32'h2408_0001, 1, 1};
        drive_req(v);
        serve(1, 1, 32'h2408_0001, 0, 1);

        // Stray mem_data_ok in IDLE.
        mem_data_ok = 1'b1; #1;
        chk("idle_stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        @(negedge clk); mem_data_ok = 1'b0; #1;
        chk("idle_stays_idle", mem_req, 0);

        for (int i = 0; i < 5; i++) begin
            drive_req(vecs[i]);
            serve(vecs[i].lat_a, vecs[i].lat_d, vecs[i].rdata, 0, 1);
        end

        // Granted master drops req in ADDR: mem_req follows, FSM holds ADDR.
        v = '{1'b1, 1'b0, SIZE_WORD, 32'h0000_0400, 32'h0, 32'h7777_0000, 0, 0};
        drive_req(v);
        @(negedge clk); #1;
        chk("drop_pre_req", mem_req, 1);
        inst_req = 1'b0; #1;
        chk("drop_follow", mem_req, 0);
        @(negedge clk); #1;
        chk("drop_hold", mem_req, 0);
        inst_req = 1'b1; #1;
        chk("drop_still_addr", mem_req, 1);
        serve(0, 0, 32'h7777_0000, 0, -1);

        // Simultaneous requests: data first, inst after one bubble.
        v = '{1'b0, 1'b0, SIZE_WORD, 32'h8000_5000, 32'h0, 32'hAAAA_0001, 0, 0};
        drive_req(v);
        v = '{1'b1, 1'b0, SIZE_WORD, 32'h0000_5000, 32'h0, 32'hBBBB_0002, 0, 0};
        drive_req(v);
        serve(0, 0, 32'hAAAA_0001, 0, 1);
        serve(1, 0, 32'hBBBB_0002, 0, 1);

        // Starvation: data held high throughout, inst pending.
        v = '{1'b0, 1'b0, SIZE_WORD, 32'h8000_0200, 32'h0, 32'h0, 0, 0};
        for (int i = 0; i < 4; i++) drive_req(v);
        v = '{1'b1, 1'b0, SIZE_WORD, 32'h0000_0100, 32'h0, 32'h0, 0, 0};
        drive_req(v);
        v = '{1'b0, 1'b0, SIZE_WORD, 32'h8000_0200, 32'h0, 32'h0, 0, 0};
        exp_q.push_back('{1'b0, 1'b0, SIZE_WORD, 32'h8000_0200, 32'h0});
        for (int i = 0; i < 6; i++) serve(0, 0, 32'h0000_1000 + 32'(i), 1, 1);
        data_req = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 0);

        // Reset while in DATA, then a stale mem_data_ok after release.
        @(negedge clk);
        data_wr = 0; data_size = SIZE_WORD; data_addr = 32'h8000_4000; data_req = 1'b1;
        @(negedge clk); #1;
        chk("r_mem_req", mem_req, 1);
        mem_addr_ok = 1'b1; #1;
        chk("r_addr_ok", data_addr_ok, 1);
        @(negedge clk); mem_addr_ok = 1'b0; data_req = 1'b0; #1;
        chk("r_in_data", mem_req, 0);
        mem_data_ok = 1'b1; rst = 1'b0; #1;
        chk("r_async_ok", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        chk("r_async_req", mem_req, 0);
        @(negedge clk); rst = 1'b1; #1;
        chk("r_stale_data_ok", data_data_ok, 0);
        @(negedge clk); mem_data_ok = 1'b0; #1;
        chk("r_idle_after", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while inst is pending before inst is forced.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 inst_req, inst_wr  input  1 each  I-cache SRAM-like request, held until inst_addr_ok.
REQ-005 inst_size  input  2;  inst_addr, inst_wdata  input  32 each  I-cache request fields, stable while inst_req=1.
REQ-006 inst_rdata  output  32;  inst_addr_ok, inst_data_ok  output  1 each  I-cache responses.
REQ-007 data_req, data_wr  input  1 each;  data_size  input  2;  data_addr, data_wdata  input  32 each  D-cache request, same rules as inst.
REQ-008 data_rdata  output  32;  data_addr_ok, data_data_ok  output  1 each  D-cache responses.
REQ-009 mem_req, mem_wr  output  1 each;  mem_size  output  2;  mem_addr, mem_wdata  output  32 each  shared downstream SRAM-like port.
REQ-010 mem_rdata  input  32;  mem_addr_ok, mem_data_ok  input  1 each  downstream responses.

Function
REQ-011 FSM states: IDLE, ADDR, DATA; at most one outstanding transaction.
REQ-012 IDLE: if any req=1, register grant (INST or DATA), go ADDR next cycle; mem_req=0 in IDLE.
REQ-013 Arbitration: data wins ties unless the starvation counter equals STARVE_LIMIT and inst_req=1, then inst wins; a lone requester always wins.
REQ-014 Starvation counter: increments on each data grant while inst_req=1, saturates at STARVE_LIMIT, clears on any inst grant.
REQ-015 ADDR: mem_req/wr/size/addr/wdata combinationally equal the granted master's fields; the other master sees addr_ok=0.
REQ-016 ADDR: granted master's addr_ok = mem_addr_ok in the same cycle; on mem_addr_ok=1 go DATA.
REQ-017 DATA: mem_req=0; granted master's data_ok = mem_data_ok in the same cycle; on mem_data_ok=1 go IDLE.
REQ-018 inst_rdata and data_rdata both equal mem_rdata; only data_ok strobes are gated by grant.
REQ-019 Latency: request visible in IDLE at cycle N -> mem_req=1 at N+1; one IDLE bubble between back-to-back transactions.
REQ-020 mem_data_ok in IDLE or ADDR is ignored and produces no master data_ok.
REQ-021 Granted master dropping req in ADDR: mem_req follows it to 0, FSM stays ADDR (protocol violation, no recovery required).
REQ-022 Grant and FSM never change while in ADDR or DATA regardless of the other master's req.

Reset
REQ-023 rst=0 asynchronously forces IDLE, grant=INST, starvation counter=0.
REQ-024 During reset all *_addr_ok, *_data_ok, mem_req = 0; rdata outputs follow mem_rdata.
REQ-025 Reset mid-transaction abandons it; no response is issued for it after release.
REQ-026 First arbitration happens on the first rising edge with rst=1.

Structure
REQ-027 Shared package holds FSM state encoding, grant ID constants (GNT_INST, GNT_DATA) and the SRAM-like size encodings (byte/half/word).
REQ-028 Single flat module; arbitration is a local function, no sub-module.
REQ-029 Only the FSM, grant and starvation counter are registered; all port forwarding is combinational.

Verification
REQ-030 inst_req only, addr 0xBFC00000; mem_addr_ok at cycle 2, mem_data_ok with rdata 0x24080001 at cycle 4 -> mem_addr=0xBFC00000 from cycle 1, inst_addr_ok at 2, inst_data_ok with rdata 0x24080001 at 4, data_*_ok stay 0.
REQ-031 inst_req and data_req both at cycle 0 -> data granted first, inst granted in IDLE after data_data_ok, mem_addr switches to inst_addr.
REQ-032 data_req held high continuously, inst_req held high, STARVE_LIMIT=4 -> exactly 4 data transactions, then 1 inst, then data resumes.
REQ-033 Data write, size=2, addr 0x80001000, wdata 0xDEADBEEF -> mem_wr=1, mem_size=2, mem_wdata=0xDEADBEEF during ADDR; mem_req=0 in DATA.
REQ-034 rst=0 asserted in DATA state -> all ok outputs and mem_req=0 immediately; a stale mem_data_ok after release yields no data_ok.
REQ-035 mem_data_ok pulsed in IDLE with no request -> no inst_data_ok/data_data_ok, FSM stays IDLE.
